vram_dual_port_writer: RTL



---
 rtl/vram_dual_port_writer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_dual_port_writer.sv
// vram_dual_port_writer: request FIFO in front of one dual-port VRAM bank.
// Writes drain two per cycle across ports A and B; reads issue on port A
// and return through a fixed-latency response pipe.
// Optional feature: define VRAM_WR_MERGE_EN to merge a same-address write
// pair into a single port-A write.
module vram_dual_port_writer #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wrdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rddata,
  output logic                  idle,
  output logic [ADDR_W-1:0]     addr_a,
  output logic [ADDR_W-1:0]     addr_b,
  output logic [DATA_W-1:0]     wrdata_a,
  output logic [DATA_W-1:0]     wrdata_b,
  output logic                  wren_a,
  output logic                  wren_b,
  output logic [DATA_W/8-1:0]   byteena_a,
  output logic [DATA_W/8-1:0]   byteena_b,
  input  logic [DATA_W-1:0]     rddata_a
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ACT_IDLE, ACT_ISSUE1W, ACT_ISSUE1R, ACT_ISSUE2, ACT_MERGE
  } act_e;

  logic                r_q_we   [DEPTH];
  logic [ADDR_W-1:0]   r_q_addr [DEPTH];
  logic [DATA_W-1:0]   r_q_data [DEPTH];
  logic [BE_W-1:0]     r_q_be   [DEPTH];

  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [RD_LAT-1:0]   r_rd_sr;

  logic                w_accept;
  logic [PTR_W-1:0]    w_rptr1;
  logic                w_h1_from_q, w_h1_valid;
  logic                w_h_we, w_h1_we;
  logic [ADDR_W-1:0]   w_h_addr, w_h1_addr;
  logic [DATA_W-1:0]   w_h_data, w_h1_data;
  logic [BE_W-1:0]     w_h_be, w_h1_be;
  act_e                w_act;
  logic [1:0]          w_pop;

  assign req_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign w_rptr1   = r_rptr + PTR_W'(1);

  // With exactly one entry queued, a write arriving this cycle can act as
  // the pairing partner H+1 so that back-to-back writes use both ports.
  assign w_h1_from_q = (r_count >= CNT_W'(2));
  assign w_h1_valid  = w_h1_from_q || ((r_count == CNT_W'(1)) && w_accept);

  assign w_h_we    = r_q_we[r_rptr];
  assign w_h_addr  = r_q_addr[r_rptr];
  assign w_h_data  = r_q_data[r_rptr];
  assign w_h_be    = r_q_be[r_rptr];
  assign w_h1_we   = w_h1_from_q ? r_q_we[w_rptr1]   : req_we;
  assign w_h1_addr = w_h1_from_q ? r_q_addr[w_rptr1] : req_addr;
  assign w_h1_data = w_h1_from_q ? r_q_data[w_rptr1] : req_wrdata;
  assign w_h1_be   = w_h1_from_q ? r_q_be[w_rptr1]   : req_be;

`ifdef VRAM_WR_MERGE_EN
  logic [DATA_W-1:0] w_merge_data;

  // Merged write data: bytes enabled by the younger write win.
  always_comb begin
    w_merge_data = w_h_data;
    for (int b = 0; b < BE_W; b++)
      if (w_h1_be[b]) w_merge_data[b*8 +: 8] = w_h1_data[b*8 +: 8];
  end
`endif

  // Drain decision on the head pair; reads are never paired.
  always_comb begin
    w_act = ACT_IDLE;
    w_pop = 2'd0;
    if (r_count != '0) begin
      if (!w_h_we) begin
        w_act = ACT_ISSUE1R;
        w_pop = 2'd1;
      end else if (w_h1_valid && w_h1_we && (w_h1_addr != w_h_addr)) begin
        w_act = ACT_ISSUE2;
        w_pop = 2'd2;
`ifdef VRAM_WR_MERGE_EN
      end else if (w_h1_valid && w_h1_we) begin
        w_act = ACT_MERGE;
        w_pop = 2'd2;
`endif
      end else begin
        w_act = ACT_ISSUE1W;
        w_pop = 2'd1;
      end
    end
  end

  // FIFO payload storage; carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_we[r_wptr]   <= req_we;
      r_q_addr[r_wptr] <= req_addr;
      r_q_data[r_wptr] <= req_wrdata;
      r_q_be[r_wptr]   <= req_be;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + PTR_W'(1);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
    end
  end

  // Register the chosen action onto the RAM ports; addresses and data hold when unused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a    <= '0;
      addr_b    <= '0;
      wrdata_a  <= '0;
      wrdata_b  <= '0;
      wren_a    <= 1'b0;
      wren_b    <= 1'b0;
      byteena_a <= '0;
      byteena_b <= '0;
    end else begin
      wren_a    <= 1'b0;
      wren_b    <= 1'b0;
      byteena_a <= '0;
      byteena_b <= '0;
      case (w_act)
        ACT_ISSUE1R: begin
          addr_a <= w_h_addr;
        end
        ACT_ISSUE1W: begin
          addr_a    <= w_h_addr;
          wrdata_a  <= w_h_data;
          wren_a    <= 1'b1;
          byteena_a <= w_h_be;
        end
        ACT_ISSUE2: begin
          addr_a    <= w_h_addr;
          wrdata_a  <= w_h_data;
          wren_a    <= 1'b1;
          byteena_a <= w_h_be;
          addr_b    <= w_h1_addr;
          wrdata_b  <= w_h1_data;
          wren_b    <= 1'b1;
          byteena_b <= w_h1_be;
        end
`ifdef VRAM_WR_MERGE_EN
        ACT_MERGE: begin
          addr_a    <= w_h_addr;
          wrdata_a  <= w_merge_data;
          wren_a    <= 1'b1;
          byteena_a <= w_h_be | w_h1_be;
        end
`endif
        default: ;
      endcase
    end
  end

  // Track reads in flight and register returning RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sr    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rddata <= '0;
    end else begin
      r_rd_sr[0] <= (w_act == ACT_ISSUE1R);
      for (int i = 1; i < RD_LAT; i++) r_rd_sr[i] <= r_rd_sr[i-1];
      rsp_valid <= r_rd_sr[RD_LAT-1];
      if (r_rd_sr[RD_LAT-1]) rsp_rddata <= rddata_a;
    end
  end

  assign idle = (r_count == '0) && !wren_a && !wren_b && (r_rd_sr == '0) && !rsp_valid;

endmodule
